// File: rtl/fm_packer_if.sv
// fm_packer_if: handshake and flat-bus signals between a feature-map
// producer, the fm_packer block and the flat-bus consumer.
// master = element producer / consumer side, slave = fm_packer.
interface fm_packer_if #(
  parameter int fm_width   = 5,
  parameter int fm_height  = 5,
  parameter int value_size = 16
);
  localparam int N  = fm_width * fm_height;
  localparam int CW = $clog2(N + 1);

  logic                    in_valid;
  logic                    in_ready;
  logic [value_size-1:0]   in_data;
  logic                    in_last;
  logic [N*value_size-1:0] fm_out;
  logic                    fm_valid;
  logic                    fm_ack;
  logic [CW-1:0]           count;
  logic                    err_len;

  modport master (
    output in_valid, in_data, in_last, fm_ack,
    input  in_ready, fm_out, fm_valid, count, err_len
  );

  modport slave (
    input  in_valid, in_data, in_last, fm_ack,
    output in_ready, fm_out, fm_valid, count, err_len
  );
endinterface

// File: rtl/fm_packer.sv
// fm_packer: collects a row-major feature map one element per cycle and
// presents it on a flat N*value_size bus, first element in the most
// significant slot. The packed map is held with fm_valid until fm_ack.
// Optional macro FM_PACK_RELU_EN: negative elements are stored as zero,
// so the packed map comes out already rectified.
module fm_packer #(
  parameter int fm_width   = 5,
  parameter int fm_height  = 5,
  parameter int value_size = 16
) (
  input logic          clk,
  input logic          rst_n,
  fm_packer_if.slave   bus
);
  localparam int N  = fm_width * fm_height;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(N);

  typedef enum logic {
    FILL,
    FULL
  } state_t;

  state_t                  r_state;
  logic                    r_inReady;
  logic                    r_fmValid;
  logic                    r_errLen;
  logic [CW-1:0]           r_count;
  logic [N*value_size-1:0] r_fmOut;

  logic                    w_accept;
  logic [value_size-1:0]   w_storeData;
  int                      w_slotBase;

  // Accept condition, element value to store, and the slot it lands in
  always_comb begin
    w_accept   = bus.in_valid && r_inReady;
    w_slotBase = (N - 1 - int'(r_count)) * value_size;
`ifdef FM_PACK_RELU_EN
    w_storeData = bus.in_data[value_size-1] ? '0 : bus.in_data;
`else
    w_storeData = bus.in_data;
`endif
  end

  // Fill/hold state machine; all outputs registered here
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= FILL;
      r_inReady <= 1'b0;
      r_fmValid <= 1'b0;
      r_errLen  <= 1'b0;
      r_count   <= '0;
      r_fmOut   <= '0;
    end else begin
      case (r_state)
        FILL: begin
          r_inReady <= 1'b1;
          if (w_accept) begin
            if (r_count == LAST_IDX) begin
              r_fmOut[w_slotBase +: value_size] <= w_storeData;
              r_count   <= FULL_CNT;
              r_state   <= FULL;
              r_fmValid <= 1'b1;
              r_inReady <= 1'b0;
              if (!bus.in_last) begin
                r_errLen <= 1'b1;
              end
            end else if (bus.in_last) begin
              r_errLen <= 1'b1;
              r_count  <= '0;
            end else begin
              r_fmOut[w_slotBase +: value_size] <= w_storeData;
              r_count <= r_count + CW'(1);
            end
          end
        end
        FULL: begin
          if (bus.fm_ack) begin
            r_state   <= FILL;
            r_fmValid <= 1'b0;
            r_inReady <= 1'b1;
            r_count   <= '0;
          end
        end
        default: begin
          r_state <= FILL;
        end
      endcase
    end
  end

  assign bus.in_ready = r_inReady;
  assign bus.fm_valid = r_fmValid;
  assign bus.err_len  = r_errLen;
  assign bus.count    = r_count;
  assign bus.fm_out   = r_fmOut;
endmodule

// File: tb/tb_fm_packer.sv
// tb_fm_packer: randomized bench for fm_packer with a frame-level
// reference model (list of stored slot values plus handshake flags).
module tb_fm_packer;
  localparam int W  = 5;
  localparam int H  = 5;
  localparam int VS = 16;
  localparam int N  = W * H;
  localparam int FW = N * VS;

  logic clk;
  logic rstN;

  fm_packer_if #(.fm_width(W), .fm_height(H), .value_size(VS)) bus ();

  fm_packer #(.fm_width(W), .fm_height(H), .value_size(VS)) u_dut (
    .clk   (clk),
    .rst_n (rstN),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [VS-1:0] slots [N];
  logic [VS-1:0] stim [N];
  int   mCount;
  bit   mReady;
  bit   mFull;
  bit   mErr;
  bit   mAcc;
  int   feedCycles;

  function automatic logic [VS-1:0] storedValue(input logic [VS-1:0] d);
`ifdef FM_PACK_RELU_EN
    return ($signed(d) < 0) ? '0 : d;
`else
    return d;
`endif
  endfunction

  // first received element ends up in the top slot
  function automatic logic [FW-1:0] packedModel();
    logic [FW-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r = {r[FW-VS-1:0], slots[k]};
    return r;
  endfunction

  // one clock: drive inputs, let the edge happen, advance the model
  task automatic tick(input logic v, input logic [VS-1:0] d, input logic last,
                      input logic ack, input logic rst);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.fm_ack   = ack;
    rstN         = rst;
    @(posedge clk);
    #1;
    mAcc = 1'b0;
    if (!rst) begin
      mCount = 0; mReady = 0; mFull = 0; mErr = 0;
      for (int k = 0; k < N; k++) slots[k] = '0;
    end else if (mFull) begin
      if (ack) begin mFull = 0; mReady = 1; mCount = 0; end
    end else if (!mReady) begin
      mReady = 1;
    end else if (v) begin
      mAcc = 1'b1;
      if (mCount == N - 1) begin
        slots[mCount] = storedValue(d);
        mCount = N; mFull = 1; mReady = 0;
        if (!last) mErr = 1;
      end else if (last) begin
        mErr = 1; mCount = 0;
      end else begin
        slots[mCount] = storedValue(d);
        mCount++;
      end
    end
  endtask

  // feed stim[from..upto-1] with random idle beats; busyPct = idle chance
  task automatic feed(input int from, input int upto, input int lastIdx, input int busyPct);
    int idx;
    int guard;
    logic v;
    idx = from;
    guard = 0;
    feedCycles = 0;
    while (idx < upto && guard < 2000) begin
      v = ($urandom_range(0, 99) >= busyPct);
      tick(v, v ? stim[idx] : VS'($urandom), v && (idx == lastIdx), 1'b0, 1'b1);
      if (mAcc) idx++;
      guard++;
      feedCycles++;
    end
    if (idx < upto) begin
      checks++; errors++;
      $display("[TB] FAIL feed_timeout: accepted %0d required %0d", idx, upto);
    end
  endtask

  task automatic test_reset();
    tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    checks++; if (bus.fm_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_fm_valid: got %b want 0", bus.fm_valid); end
    checks++; if (bus.count !== '0) begin errors++; $display("[TB] FAIL reset_count: got %0d want 0", bus.count); end
    checks++; if (bus.fm_out !== '0) begin errors++; $display("[TB] FAIL reset_fm_out: got %h want 0", bus.fm_out); end
    checks++; if (bus.err_len !== 1'b0) begin errors++; $display("[TB] FAIL reset_err_len: got %b want 0", bus.err_len); end
    tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready_rise: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_basic_frame();
    for (int k = 0; k < N; k++) stim[k] = VS'(k + 1);
    feed(0, N - 1, N - 1, 0);
    checks++; if (bus.fm_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_valid: got %b want 0", bus.fm_valid); end
    checks++; if (bus.count !== 5'(N - 1)) begin errors++; $display("[TB] FAIL basic_count24: got %0d want %0d", bus.count, N - 1); end
    feed(N - 1, N, N - 1, 0);
    checks++; if (bus.fm_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_fm_valid: got %b want 1", bus.fm_valid); end
    checks++; if (bus.fm_out[399:384] !== 16'h0001) begin errors++; $display("[TB] FAIL basic_top_slot: got %h want 0001", bus.fm_out[399:384]); end
    checks++; if (bus.fm_out[15:0] !== 16'h0019) begin errors++; $display("[TB] FAIL basic_bottom_slot: got %h want 0019", bus.fm_out[15:0]); end
    checks++; if (bus.count !== 5'(N)) begin errors++; $display("[TB] FAIL basic_count: got %0d want %0d", bus.count, N); end
    checks++; if (bus.err_len !== 1'b0) begin errors++; $display("[TB] FAIL basic_err_len: got %b want 0", bus.err_len); end
    checks++; if (bus.fm_out !== packedModel()) begin errors++; $display("[TB] FAIL basic_fm_out: got %h want %h", bus.fm_out, packedModel()); end
  endtask

  task automatic test_hold_full();
    for (int c = 0; c < 10; c++) begin
      tick(1'b1, 16'hdead, 1'b0, 1'b0, 1'b1);
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_in_ready: cycle %0d got %b want 0", c, bus.in_ready); end
      checks++; if (bus.fm_out !== packedModel()) begin errors++; $display("[TB] FAIL hold_fm_out: cycle %0d got %h want %h", c, bus.fm_out, packedModel()); end
    end
    checks++; if (bus.count !== 5'(N)) begin errors++; $display("[TB] FAIL hold_count: got %0d want %0d", bus.count, N); end
    tick(1'b1, 16'hdead, 1'b0, 1'b1, 1'b1);
    checks++; if (bus.fm_valid !== 1'b0) begin errors++; $display("[TB] FAIL ack_fm_valid: got %b want 0", bus.fm_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL ack_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.count !== '0) begin errors++; $display("[TB] FAIL ack_count: got %0d want 0", bus.count); end
  endtask

  task automatic test_alternating();
    logic [VS-1:0] topExp;
    for (int k = 0; k < N; k++) stim[k] = (k % 2 == 0) ? 16'hffff : 16'h0fff;
    feed(0, N, N - 1, 40);
`ifdef FM_PACK_RELU_EN
    topExp = 16'h0000;
`else
    topExp = 16'hffff;
`endif
    checks++; if (bus.fm_valid !== 1'b1) begin errors++; $display("[TB] FAIL alt_fm_valid: got %b want 1", bus.fm_valid); end
    checks++; if (bus.fm_out[399:384] !== topExp) begin errors++; $display("[TB] FAIL alt_top_slot: got %h want %h", bus.fm_out[399:384], topExp); end
    checks++; if (bus.fm_out[383:368] !== 16'h0fff) begin errors++; $display("[TB] FAIL alt_second_slot: got %h want 0fff", bus.fm_out[383:368]); end
    checks++; if (bus.fm_out !== packedModel()) begin errors++; $display("[TB] FAIL alt_fm_out: got %h want %h", bus.fm_out, packedModel()); end
    tick(1'b0, '0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_short_frame();
    for (int k = 0; k < N; k++) stim[k] = VS'($urandom);
    feed(0, 7, 6, 30);
    checks++; if (bus.err_len !== 1'b1) begin errors++; $display("[TB] FAIL short_err_len: got %b want 1", bus.err_len); end
    checks++; if (bus.count !== '0) begin errors++; $display("[TB] FAIL short_count: got %0d want 0", bus.count); end
    checks++; if (bus.fm_valid !== 1'b0) begin errors++; $display("[TB] FAIL short_fm_valid: got %b want 0", bus.fm_valid); end
    for (int k = 0; k < N; k++) stim[k] = VS'($urandom);
    feed(0, N, N - 1, 30);
    checks++; if (bus.fm_valid !== 1'b1) begin errors++; $display("[TB] FAIL short_next_valid: got %b want 1", bus.fm_valid); end
    checks++; if (bus.fm_out !== packedModel()) begin errors++; $display("[TB] FAIL short_next_fm_out: got %h want %h", bus.fm_out, packedModel()); end
    checks++; if (bus.err_len !== 1'b1) begin errors++; $display("[TB] FAIL short_err_sticky: got %b want 1", bus.err_len); end
    tick(1'b0, '0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_long_frame();
    tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checks++; if (bus.err_len !== 1'b0) begin errors++; $display("[TB] FAIL long_err_cleared: got %b want 0", bus.err_len); end
    for (int k = 0; k < N; k++) stim[k] = VS'($urandom);
    feed(0, N, -1, 20);
    checks++; if (bus.fm_valid !== 1'b1) begin errors++; $display("[TB] FAIL long_fm_valid: got %b want 1", bus.fm_valid); end
    checks++; if (bus.err_len !== 1'b1) begin errors++; $display("[TB] FAIL long_err_len: got %b want 1", bus.err_len); end
    checks++; if (bus.fm_out !== packedModel()) begin errors++; $display("[TB] FAIL long_fm_out: got %h want %h", bus.fm_out, packedModel()); end
    tick(1'b0, '0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k < N; k++) stim[k] = VS'($urandom);
    feed(0, 12, -1, 25);
    tick(1'b0, '0, 1'b0, 1'b1, 1'b1);
    checks++; if (bus.count !== 5'(12)) begin errors++; $display("[TB] FAIL fill_ack_ignored: got %0d want 12", bus.count); end
    tick(1'b1, 16'h5555, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.count !== '0) begin errors++; $display("[TB] FAIL midrst_count: got %0d want 0", bus.count); end
    checks++; if (bus.fm_out !== '0) begin errors++; $display("[TB] FAIL midrst_fm_out: got %h want 0", bus.fm_out); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_in_ready: got %b want 0", bus.in_ready); end
    tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ready_rise: got %b want 1", bus.in_ready); end
    for (int k = 0; k < N; k++) stim[k] = VS'($urandom);
    feed(0, N, N - 1, 25);
    checks++; if (bus.fm_out !== packedModel()) begin errors++; $display("[TB] FAIL midrst_frame: got %h want %h", bus.fm_out, packedModel()); end
    checks++; if (bus.count !== 5'(N)) begin errors++; $display("[TB] FAIL midrst_frame_count: got %0d want %0d", bus.count, N); end
  endtask

  task automatic test_back_to_back();
    tick(1'b0, '0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < N; k++) stim[k] = VS'($urandom);
    feed(0, N, N - 1, 0);
    checks++; if (feedCycles != N) begin errors++; $display("[TB] FAIL b2b_cycles: got %0d want %0d", feedCycles, N); end
    checks++; if (bus.fm_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_fm_valid: got %b want 1", bus.fm_valid); end
    checks++; if (bus.fm_out !== packedModel()) begin errors++; $display("[TB] FAIL b2b_fm_out: got %h want %h", bus.fm_out, packedModel()); end
  endtask

  initial begin
    rstN = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.fm_ack   = 1'b0;
    mCount = 0; mReady = 0; mFull = 0; mErr = 0; mAcc = 0;
    for (int k = 0; k < N; k++) slots[k] = '0;
    test_reset();
    test_basic_frame();
    test_hold_full();
    test_alternating();
    test_short_frame();
    test_long_frame();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
